// File: rtl/scan_mem_reg_mux.sv
// scan_mem_reg_mux: routes single-cycle scan accesses to either the SRAM port
// (fixed read latency) or the register-bank port (req/ack with timeout).
// It returns a one-cycle scan_ready completion pulse and keeps sticky error
// and drop flags.
//
// Handshake contract: a request is any cycle with scan_wen or scan_ren high.
// A write wins if both are high. Requests are taken only in IDLE; any other
// request sets drop_flag and is otherwise ignored. Each accepted access gets
// exactly one scan_ready pulse, unless reset abandons it first. On the SRAM
// side, mem_en is a one-cycle strobe and mem_rdata is sampled MEM_RD_LAT
// cycles later. On the register side, reg_req is held with stable
// reg_we/reg_addr/reg_wdata until the cycle reg_ack is seen, or until the
// REG_TIMEOUT-th cycle expires.
module scan_mem_reg_mux #(
    parameter int          MEM_RD_LAT  = 2,
    parameter int          REG_TIMEOUT = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_wen,
    input  logic        scan_ren,
    input  logic [13:0] scan_addr,
    input  logic [31:0] scan_wdata,
    output logic [31:0] scan_rdata,
    output logic        scan_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        reg_req,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    input  logic        err_clr,
    output logic        err_flag,
    output logic        drop_flag
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_ACC  = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_REG_WAIT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [7:0] LAT_CNT = 8'(MEM_RD_LAT);
    localparam logic [7:0] TO_CNT  = 8'(REG_TIMEOUT);

    // state is the observable FSM state for checkers
    state_t state;
    state_t next_state;

    // Accepted access context
    logic [12:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    // Shared cycle counter: SRAM latency in MEM_WAIT, reg_req age in REG_WAIT
    logic [7:0]  cnt;

    logic        req;
    logic        out_of_range;
    logic        accept;

    // Next-cycle values of the registered outputs
    logic        cur_we;
    logic [12:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [7:0]  cnt_d;
    logic        scan_ready_d;
    logic [31:0] scan_rdata_d;
    logic        mem_en_d;
    logic        mem_we_d;
    logic [12:0] mem_addr_d;
    logic [31:0] mem_wdata_d;
    logic        reg_req_d;
    logic        reg_we_d;
    logic [7:0]  reg_addr_d;
    logic [31:0] reg_wdata_d;
    logic        err_set;
    logic        drop_set;

    assign req          = scan_wen | scan_ren;
    assign out_of_range = scan_addr[13] & (|scan_addr[12:8]);
    assign accept       = req && (state == S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (!scan_addr[13]) begin
                        next_state = S_MEM_ACC;
                    end else if (out_of_range) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_REG_WAIT;
                    end
                end
            end
            S_MEM_ACC:  next_state = we_q ? S_DONE : S_MEM_WAIT;
            S_MEM_WAIT: if (cnt == LAT_CNT) next_state = S_DONE;
            S_REG_WAIT: if (reg_ack || (cnt == TO_CNT)) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output logic: next-cycle values of every registered output
    always_comb begin
        // In IDLE the access context has not been registered yet, so take it
        // straight from the request inputs.
        cur_we       = (state == S_IDLE) ? scan_wen : we_q;
        cur_addr     = (state == S_IDLE) ? scan_addr[12:0] : addr_q;
        cur_wdata    = (state == S_IDLE) ? scan_wdata : wdata_q;

        mem_en_d     = (next_state == S_MEM_ACC);
        mem_we_d     = mem_en_d & cur_we;
        mem_addr_d   = mem_en_d ? cur_addr : 13'd0;
        mem_wdata_d  = mem_we_d ? cur_wdata : 32'd0;

        reg_req_d    = (next_state == S_REG_WAIT);
        reg_we_d     = reg_req_d & cur_we;
        reg_addr_d   = reg_req_d ? cur_addr[7:0] : 8'd0;
        reg_wdata_d  = reg_we_d ? cur_wdata : 32'd0;

        scan_ready_d = (next_state == S_DONE);
        scan_rdata_d = scan_rdata;
        err_set      = 1'b0;
        drop_set     = req && (state != S_IDLE);
        cnt_d        = cnt;

        case (state)
            S_IDLE: begin
                cnt_d = 8'd1;
                if (req && scan_addr[13] && out_of_range) begin
                    err_set = 1'b1;
                    if (!scan_wen) scan_rdata_d = ERR_DATA;
                end
            end
            S_MEM_ACC: begin
                cnt_d = 8'd1;
            end
            S_MEM_WAIT: begin
                cnt_d = cnt + 8'd1;
                if (cnt == LAT_CNT) scan_rdata_d = mem_rdata;
            end
            S_REG_WAIT: begin
                cnt_d = cnt + 8'd1;
                if (reg_ack) begin
                    if (!we_q) scan_rdata_d = reg_rdata;
                end else if (cnt == TO_CNT) begin
                    err_set = 1'b1;
                    if (!we_q) scan_rdata_d = ERR_DATA;
                end
            end
            default: begin
                cnt_d = cnt;
            end
        endcase
    end

    // Registered outputs, counter and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ready <= 1'b0;
            scan_rdata <= 32'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 13'd0;
            mem_wdata  <= 32'd0;
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= 8'd0;
            reg_wdata  <= 32'd0;
            err_flag   <= 1'b0;
            drop_flag  <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            scan_ready <= scan_ready_d;
            scan_rdata <= scan_rdata_d;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            reg_req    <= reg_req_d;
            reg_we     <= reg_we_d;
            reg_addr   <= reg_addr_d;
            reg_wdata  <= reg_wdata_d;
            cnt        <= cnt_d;
            // A set event in the same cycle as err_clr wins
            if (err_set)       err_flag <= 1'b1;
            else if (err_clr)  err_flag <= 1'b0;
            if (drop_set)      drop_flag <= 1'b1;
            else if (err_clr)  drop_flag <= 1'b0;
        end
    end

    // Capture the access context on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 13'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= scan_addr[12:0];
            wdata_q <= scan_wdata;
            we_q    <= scan_wen;
        end
    end

endmodule

// File: tb/tb_scan_mem_reg_mux.sv
// Testbench for scan_mem_reg_mux: directed scan accesses against an SRAM
// model, with hand-computed completion cycles and read data queued for a
// monitor that checks every scan_ready pulse.
module tb_scan_mem_reg_mux;

    localparam int LAT = 2;
    localparam int TO  = 16;

    logic        clk;
    logic        rst;
    logic        scan_wen;
    logic        scan_ren;
    logic [13:0] scan_addr;
    logic [31:0] scan_wdata;
    logic [31:0] scan_rdata;
    logic        scan_ready;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        err_clr;
    logic        err_flag;
    logic        drop_flag;

    int n_vec;
    int n_bad;
    int cyc;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    scan_mem_reg_mux #(
        .MEM_RD_LAT (LAT),
        .REG_TIMEOUT(TO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_wen  (scan_wen),
        .scan_ren  (scan_ren),
        .scan_addr (scan_addr),
        .scan_wdata(scan_wdata),
        .scan_rdata(scan_rdata),
        .scan_ready(scan_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .err_clr   (err_clr),
        .err_flag  (err_flag),
        .drop_flag (drop_flag)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model: data valid only LAT cycles after mem_en
    logic [31:0] mem [0:8191];
    logic        pipe_v [0:LAT-1];
    logic [31:0] pipe_d [0:LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe_v[0] <= mem_en && !mem_we;
        pipe_d[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'h0BAD_0BAD;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && scan_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready: scan_ready at cycle %0d with rdata %h, none expected",
                         cyc, scan_rdata);
            end else begin
                logic [31:0] ed;
                int          ec;
                ed = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (scan_rdata !== ed || cyc != ec) begin
                    n_bad++;
                    $display("FAIL ready_data: got rdata %h at cycle %0d, expected %h at cycle %0d",
                             scan_rdata, cyc, ed, ec);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle request pulse; returns with time in cycle 1
    task automatic issue(input logic wen, input logic ren, input logic [13:0] addr,
                         input logic [31:0] wdata, output int c0);
        next_cycle();
        c0         = cyc;
        scan_wen   = wen;
        scan_ren   = ren;
        scan_addr  = addr;
        scan_wdata = wdata;
        next_cycle();
        scan_wen   = 1'b0;
        scan_ren   = 1'b0;
        scan_addr  = 14'd0;
        scan_wdata = 32'd0;
    endtask

    task automatic expect_ready(input int c, input logic [31:0] d);
        exp_cyc_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            next_cycle();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: %0d completions still pending", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        next_cycle();
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int bad_req;
        n_vec      = 0;
        n_bad      = 0;
        cyc        = 0;
        rst        = 1'b1;
        scan_wen   = 1'b0;
        scan_ren   = 1'b0;
        scan_addr  = 14'd0;
        scan_wdata = 32'd0;
        reg_rdata  = 32'd0;
        reg_ack    = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();

        // Reset state
        chk("rst_ready", {31'd0, scan_ready}, 32'd0);
        chk("rst_rdata", scan_rdata, 32'd0);
        chk("rst_strobes", {26'd0, mem_en, mem_we, reg_req, reg_we, err_flag, drop_flag}, 32'd0);
        chk("rst_buses", {11'd0, mem_addr, reg_addr}, 32'd0);
        chk("rst_wdata", mem_wdata | reg_wdata, 32'd0);

        // SRAM write 0x0123: mem_en/mem_we in cycle 1, ready in cycle 2
        issue(1'b1, 1'b0, 14'h0123, 32'hA5A5_0001, c0);
        expect_ready(c0 + 2, 32'd0);
        chk("memw_en_we", {30'd0, mem_en, mem_we}, 32'd3);
        chk("memw_addr", {19'd0, mem_addr}, 32'h0123);
        chk("memw_wdata", mem_wdata, 32'hA5A5_0001);
        chk("memw_noreq", {31'd0, reg_req}, 32'd0);
        wait_done("memw");

        // SRAM read 0x0123: ready in cycle 4 with the written data
        issue(1'b0, 1'b1, 14'h0123, 32'd0, c0);
        expect_ready(c0 + 2 + LAT, 32'hA5A5_0001);
        chk("memr_en_we", {30'd0, mem_en, mem_we}, 32'd2);
        wait_done("memr");

        // Register read 0x2010, ack in cycle 3
        issue(1'b0, 1'b1, 14'h2010, 32'd0, c0);
        expect_ready(c0 + 4, 32'h0000_BEEF);
        chk("regr_req_c1", {23'd0, reg_req, reg_addr}, 32'h110);
        chk("regr_we", {31'd0, reg_we}, 32'd0);
        next_cycle();
        chk("regr_req_c2", {31'd0, reg_req}, 32'd1);
        next_cycle();
        reg_ack   = 1'b1;
        reg_rdata = 32'h0000_BEEF;
        chk("regr_req_c3", {31'd0, reg_req}, 32'd1);
        next_cycle();
        reg_ack   = 1'b0;
        reg_rdata = 32'd0;
        chk("regr_req_c4", {23'd0, reg_req, reg_addr}, 32'd0);
        wait_done("regr");
        chk("regr_err", {31'd0, err_flag}, 32'd0);

        // Register write 0x2005 with ack in cycle 1: fastest completion, cycle 2
        issue(1'b1, 1'b0, 14'h2005, 32'h1234_5678, c0);
        reg_ack = 1'b1;
        expect_ready(c0 + 2, 32'h0000_BEEF);
        chk("regw_we_addr", {23'd0, reg_we, reg_addr}, 32'h105);
        chk("regw_wdata", reg_wdata, 32'h1234_5678);
        next_cycle();
        reg_ack = 1'b0;
        wait_done("regw");

        // Register timeout: read 0x2001, no ack
        issue(1'b0, 1'b1, 14'h2001, 32'd0, c0);
        expect_ready(c0 + TO + 1, 32'hDEAD_BEEF);
        bad_req = 0;
        for (int k = 1; k <= TO; k++) begin
            if (reg_req !== 1'b1) bad_req++;
            if (k < TO) next_cycle();
        end
        chk("to_req_held", bad_req, 32'd0);
        next_cycle();
        chk("to_req_drop", {31'd0, reg_req}, 32'd0);
        wait_done("to");
        chk("to_err", {31'd0, err_flag}, 32'd1);
        next_cycle();
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        chk("to_err_clr", {31'd0, err_flag}, 32'd0);

        // Out-of-range write 0x3F00: ready in cycle 1, no downstream access
        issue(1'b1, 1'b0, 14'h3F00, 32'h5555_5555, c0);
        expect_ready(c0 + 1, 32'hDEAD_BEEF);
        chk("oor_noaccess", {30'd0, mem_en, reg_req}, 32'd0);
        chk("oor_ready_c1", {31'd0, scan_ready}, 32'd1);
        wait_done("oor");
        chk("oor_err", {31'd0, err_flag}, 32'd1);
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;

        // Busy drop: second request in cycle 2 of an SRAM read
        issue(1'b0, 1'b1, 14'h0123, 32'd0, c0);
        expect_ready(c0 + 2 + LAT, 32'hA5A5_0001);
        next_cycle();
        scan_wen   = 1'b1;
        scan_addr  = 14'h0040;
        scan_wdata = 32'h1111_1111;
        next_cycle();
        scan_wen   = 1'b0;
        scan_addr  = 14'd0;
        scan_wdata = 32'd0;
        chk("drop_nomem", {31'd0, mem_en}, 32'd0);
        wait_done("drop");
        chk("drop_flag", {31'd0, drop_flag}, 32'd1);

        // Reset in cycle 2 of a register access: no completion
        issue(1'b0, 1'b1, 14'h2020, 32'd0, c0);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, reg_req}, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        chk("rst_mid_flags", {30'd0, err_flag, drop_flag}, 32'd0);
        chk("rst_mid_rdata", scan_rdata, 32'd0);
        repeat (20) next_cycle();

        // SRAM write after reset completes in 2 cycles
        issue(1'b1, 1'b0, 14'h0200, 32'h0F0F_0F0F, c0);
        expect_ready(c0 + 2, 32'd0);
        chk("post_rst_memw", {30'd0, mem_en, mem_we}, 32'd3);
        wait_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_mem_reg_mux.md
# scan_mem_reg_mux

Downstream stage of the scan read/write controller inside the group scan memory/register interface. It accepts single-cycle scan access pulses on a 14-bit word address. Address bit 13 routes each access to either the on-chip SRAM port (fixed read latency) or the register-bank port (ack handshake). It returns read data and a one-cycle `scan_ready` completion pulse. The block handles one access at a time, enforces a register-bank timeout, and reports error and drop conditions on sticky flags.

## Interface
Parameters:
- `MEM_RD_LAT`, default 2: SRAM read latency in cycles. Legal range is 1..7.
- `REG_TIMEOUT`, default 16: maximum number of cycles `reg_req` is held while waiting for `reg_ack`. Legal range is 1..255.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on an errored read.

Ports:
- `clk` in 1: single clock. All logic runs on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `scan_wen` in 1: write request pulse, one cycle wide.
- `scan_ren` in 1: read request pulse, one cycle wide.
- `scan_addr` in 14: word address. Bit 13 = 0 selects SRAM; bit 13 = 1 selects the register bank.
- `scan_wdata` in 32: write data, valid with the request pulse.
- `scan_rdata` out 32: read data, valid while `scan_ready` is high.
- `scan_ready` out 1: one-cycle completion pulse, issued for both reads and writes.
- `mem_en` out 1: SRAM access strobe, one cycle wide.
- `mem_we` out 1: SRAM write enable, qualified by `mem_en`.
- `mem_addr` out 13: SRAM word address, driven from `scan_addr[12:0]`.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid `MEM_RD_LAT` cycles after the `mem_en` cycle.
- `reg_req` out 1: register access request, held high until ack or timeout.
- `reg_we` out 1: register write enable, qualified by `reg_req`.
- `reg_addr` out 8: register index, driven from `scan_addr[7:0]`.
- `reg_wdata` out 32: register write data.
- `reg_rdata` in 32: register read data, valid in the cycle `reg_ack` is high.
- `reg_ack` in 1: register access complete.
- `err_clr` in 1: clears `err_flag` and `drop_flag`.
- `err_flag` out 1: sticky. Set on register timeout or an out-of-range register address.
- `drop_flag` out 1: sticky. Set when a request arrives while the block is busy.

## Operation
- FSM states: IDLE, MEM_ACC, MEM_WAIT, REG_WAIT, DONE. Requests are accepted only in IDLE.
- A request is any cycle with `scan_wen` or `scan_ren` high. If both are high, the access is a write.
- On acceptance, the block registers the address, write data and direction.
- Routing on acceptance:
  - `scan_addr[13]` = 0: go to MEM_ACC.
  - `scan_addr[13]` = 1 and `scan_addr[12:8]` = 0: go to REG_WAIT.
  - `scan_addr[13]` = 1 and `scan_addr[12:8]` ≠ 0: out of range. Go to DONE with the error marked; no downstream access is made.
- MEM_ACC (one cycle): `mem_en` = 1 and `mem_we` = write.
  - Write: go to DONE.
  - Read: go to MEM_WAIT.
- MEM_WAIT: a latency counter runs to `MEM_RD_LAT`. `mem_rdata` is captured in the cycle the counter expires, then the FSM goes to DONE.
- REG_WAIT: `reg_req`, `reg_we`, `reg_addr` and `reg_wdata` are held stable.
  - If `reg_ack` = 1: capture `reg_rdata` (reads only), drop `reg_req`, go to DONE.
  - If `reg_ack` is still 0 in the `REG_TIMEOUT`-th cycle of `reg_req`: drop `reg_req`, mark the error, go to DONE.
- DONE (one cycle): `scan_ready` = 1, then return to IDLE.
  - An errored read drives `scan_rdata` = `ERR_DATA`.
  - A write leaves `scan_rdata` unchanged.
  - An error marks `err_flag` at the DONE edge.
- A request seen in any state other than IDLE (including DONE) is ignored and sets `drop_flag`. The in-flight access is unaffected.
- If `err_clr` and a flag-setting event occur in the same cycle, set wins.
- Downstream strobe and data outputs are 0 whenever the associated strobe is inactive.

## Timing
- Reset values: `scan_ready`, `scan_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `reg_req`, `reg_we`, `reg_addr`, `reg_wdata`, `err_flag` and `drop_flag` are all 0. The state is IDLE.
- Cycle 0 is the cycle in which the request pulse is high. All outputs are registered.
- SRAM write: `mem_en` high in cycle 1; `scan_ready` high in cycle 2.
- SRAM read: `mem_en` high in cycle 1; data captured in cycle 1+`MEM_RD_LAT`; `scan_ready` high in cycle 2+`MEM_RD_LAT` (cycle 4 at the default latency).
- Register access: `reg_req` rises in cycle 1. If `reg_ack` is first high in cycle k (k ≥ 1), `reg_req` is low from cycle k+1 and `scan_ready` is high in cycle k+1. The fastest register access therefore completes in cycle 2.
- Register timeout: `reg_req` is high for cycles 1..`REG_TIMEOUT`; `scan_ready` is high in cycle `REG_TIMEOUT`+1.
- Out-of-range register address: `scan_ready` high in cycle 1. The earliest next accepted request is in cycle 2.
- A `reg_ack` arriving outside REG_WAIT is ignored.
- Reset asserted mid-operation: all outputs clear asynchronously and the pending access is abandoned with no `scan_ready`. After reset release, the first rising edge sees IDLE.

## Test plan
- SRAM write then read, default latency: write to 0x0123 with data 0xA5A5_0001 → `mem_en`/`mem_we` in cycle 1, `scan_ready` in cycle 2. Then read 0x0123 with `mem_rdata` = 0xA5A5_0001 → `scan_ready` in cycle 4 with `scan_rdata` = 0xA5A5_0001.
- Register read with ack delayed 3 cycles: read address 0x2010 → `reg_req` in cycles 1..3, `reg_addr` = 0x10; `reg_ack` in cycle 3 with `reg_rdata` = 0x0000_BEEF → `scan_ready` in cycle 4 with `scan_rdata` = 0x0000_BEEF. `err_flag` stays 0.
- Register timeout: read 0x2001 with no ack → `reg_req` in cycles 1..16, `scan_ready` in cycle 17, `scan_rdata` = 0xDEAD_BEEF, `err_flag` = 1. Pulsing `err_clr` then clears `err_flag` to 0.
- Out-of-range address: write to 0x3F00 → no `mem_en` and no `reg_req`; `scan_ready` in cycle 1; `err_flag` = 1.
- Busy drop: issue an SRAM read, then a second request in cycle 2 → the second request is ignored, `drop_flag` = 1, and the first read still completes in cycle 4 with the correct data.
- Reset mid-access: assert `rst` in cycle 2 of a register access → `reg_req` = 0 immediately and no `scan_ready` is issued. A new SRAM write after release completes in 2 cycles.
